spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter and sequencer that shares one `spi_master` instance among up to `NPORTS` requesters, such as the CPU I/O port, a flash loader and a sensor poller. It grants one requester at a time and drives the master's `request`/`mosi_data`/`nbits` inputs. It waits for the master's `ready`, returns the read word with a one-cycle acknowledge, and routes the master's single `spi_csn` to the winner's dedicated chip-select line. It sits between the bus-side peripherals and `spi_master`. At top level, `spi_master.nrst` is tied to `~rst`.

## Interface

Parameters:
- `NPORTS`, default 4: number of requesters, legal range 1..8.
- `PW`, default 3: width of the port index; must satisfy `2**PW >= NPORTS`.

Ports:
- `clk_in`  in  1: logic clock, shared with `spi_master`.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  NPORTS: per-port transfer request; a level held high until that port's `ack`.
- `wdata`  in  32*NPORTS: per-port MOSI word; port k occupies bits [32k+31:32k].
- `wbits`  in  6*NPORTS: per-port bit count, where 0 means 1 bit; port k occupies bits [6k+5:6k].
- `ack`  out  NPORTS: one-hot, one-cycle pulse when the owner's transfer is complete.
- `rdata`  out  32: MISO word of the last completed transfer, right-aligned.
- `busy`  out  1: high from grant until `ack`, inclusive.
- `owner`  out  PW: index of the current or last granted port.
- `spi_request`  out  1: to `spi_master.request`.
- `spi_mosi_data`  out  32: to `spi_master.mosi_data`.
- `spi_nbits`  out  6: to `spi_master.nbits`.
- `spi_miso_data`  in  32: from `spi_master.miso_data`.
- `spi_ready`  in  1: from `spi_master.ready`.
- `spi_csn`  in  1: from `spi_master.spi_csn`.
- `dev_csn`  out  NPORTS: per-device chip select, active low.

## Operation

The arbiter is a state machine with five states: IDLE, GRANT, SETTLE, BUSY and DONE.

- **IDLE**
  - If `req` is non-zero, pick the winner by round robin, starting at `(last+1) mod NPORTS` and searching upward with wrap-around.
  - Register `owner` = winner.
  - Latch the winner's `wdata` into `spi_mosi_data`.
  - Latch the winner's `wbits` into `spi_nbits`, clamped: if `wbits[5]`=1, forward 31. Values 32..63 break the master's alignment loop.
  - Set `busy`=1 and go to GRANT.
- **GRANT**
  - `spi_request`=1 for exactly this cycle; the master accepts it from its idle state.
  - Go to SETTLE.
- **SETTLE**
  - One cycle with `spi_request`=0. This masks the stale `spi_ready`=1 left over from the previous transfer; the master clears ready on acceptance.
  - Go to BUSY.
- **BUSY**
  - Wait for `spi_ready`=1, then capture `rdata` ← `spi_miso_data` and go to DONE.
  - There is no timeout.
- **DONE**
  - `ack[owner]`=1 for this cycle.
  - `last` ← `owner`.
  - Go to IDLE with `busy`=0.

Chip select:
- `dev_csn[k]` = `spi_csn` when k == `owner` and `busy`=1; otherwise 1. This is combinational.

Requester rules:
- `wdata` and `wbits` need only be valid in the IDLE cycle in which the grant is made; they are not re-sampled.
- A requester must deassert `req` in the cycle after `ack`. A registered requester reacting to `ack` does this naturally.
- Dropping `req` mid-transfer does not abort the transfer; `ack` is still issued.

Other behaviour:
- `rdata` holds its value until the next DONE.
- Bits of `req` at index NPORTS and above do not exist; a single-port build always grants port 0.

## Timing

Reset values:
- `spi_request`=0, `spi_mosi_data`=0, `spi_nbits`=0.
- `ack`=0, `rdata`=0, `busy`=0, `owner`=0.
- `last`=NPORTS-1, so port 0 has first priority.
- State = IDLE; all `dev_csn`=1.

Cycle sequence, with `req` high in IDLE at cycle t:
- GRANT at t+1, with `spi_request` high.
- SETTLE at t+2.
- BUSY from t+3.
- `spi_ready` seen high at cycle r gives DONE at r+1, with `ack` high.
- IDLE at r+2.
- Arbiter overhead is 3 cycles before the master starts and 2 cycles after it finishes. A new grant is possible at r+2.

Simultaneous events:
- When several requests arrive together, only one is granted. The losers stay pending and are served in round-robin order, with no starvation. Each waits at most NPORTS-1 transfers.

Reset mid-transfer:
- Asserting `rst` returns the arbiter to its reset values immediately; `dev_csn` goes all-high at once.
- The master is reset by the same net, so no handshake is left dangling.

## Test plan

- **Single transfer:** reset; `req`=0001, `wdata0`=0xA5, `wbits0`=7, with the master's MISO looped to MOSI.
  - `spi_request` pulses at t+1.
  - `spi_nbits`=7.
  - `dev_csn`=1110 while the master's CSN is low.
  - `ack`=0001 for one cycle.
  - `rdata`=0x000000A5.
- **Round robin:** `req`=1111 held, with each port re-requesting after its `ack`.
  - Grant order is 0,1,2,3,0.
  - `ack` is never asserted for two ports at once.
- **Clamp:** `wbits1`=40.
  - `spi_nbits`=31.
  - The master shifts exactly 32 SCK cycles.
  - `rdata` is the full 32-bit looped word, e.g. 0xDEADBEEF in, 0xDEADBEEF out.
- **Stale ready:** two back-to-back transfers on port 2.
  - The second transfer must wait the full master duration; `ack` must not occur 3 cycles after the grant.
- **Abandoned request:** `req0` dropped during BUSY.
  - The transfer completes.
  - `ack`=0001 and `rdata` are updated.
  - The next grant goes to the next pending port.
- **Reset mid-transfer:** assert `rst` in BUSY.
  - All outputs return to reset values within the same cycle (asynchronous).
  - After release, `req`=0010 is granted to port 1 normally.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among NPORTS requesters.
// Grants one port at a time, sequences the master handshake and routes chip select.

module spi_arbiter_csn (
  input  logic sel,
  input  logic spi_csn,
  output logic csn
);
  assign csn = sel ? spi_csn : 1'b1;
endmodule

module spi_arbiter #(
  parameter int NPORTS = 4,
  parameter int PW     = 3
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [NPORTS-1:0]      req,
  input  logic [32*NPORTS-1:0]   wdata,
  input  logic [6*NPORTS-1:0]    wbits,
  output logic [NPORTS-1:0]      ack,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic [PW-1:0]          owner,
  output logic                   spi_request,
  output logic [31:0]            spi_mosi_data,
  output logic [5:0]             spi_nbits,
  input  logic [31:0]            spi_miso_data,
  input  logic                   spi_ready,
  input  logic                   spi_csn,
  output logic [NPORTS-1:0]      dev_csn
);
  localparam int NX  = 2**PW;
  localparam int NX2 = 2**(PW+1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SETTLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nx;
  logic [PW-1:0] last;
  logic [PW-1:0] win;
  logic          found;
  logic [PW:0]   cand;
  logic [NX2-1:0] req_x;
  logic [NPORTS-1:0][31:0] wdata_a;
  logic [NPORTS-1:0][5:0]  wbits_a;
  logic [NX-1:0][31:0] wdata_x;
  logic [NX-1:0][5:0]  wbits_x;
  logic [NX-1:0]       ack_x;

  assign wdata_a = wdata;
  assign wbits_a = wbits;

  // Widen per-port vectors to the full index space so every index is in range.
  always_comb begin
    req_x   = '0;
    wdata_x = '0;
    wbits_x = '0;
    req_x[NPORTS-1:0]   = req;
    wdata_x[NPORTS-1:0] = wdata_a;
    wbits_x[NPORTS-1:0] = wbits_a;
  end

  // Search from last+1 upward with wrap; iterating downward lets the nearest hit win.
  always_comb begin
    win   = last;
    found = 1'b0;
    cand  = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      cand = {1'b0, last} + (PW+1)'(i);
      if (cand >= (PW+1)'(NPORTS)) cand = cand - (PW+1)'(NPORTS);
      if (req_x[cand]) begin
        win   = cand[PW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (found) state_nx = S_GRANT;
      S_GRANT:  state_nx = S_SETTLE;
      // SETTLE hides the ready level left over from the previous transfer.
      S_SETTLE: state_nx = S_BUSY;
      S_BUSY:   if (spi_ready) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      owner         <= '0;
      last          <= PW'(NPORTS-1);
      spi_mosi_data <= '0;
      spi_nbits     <= '0;
      rdata         <= '0;
    end else begin
      if (state == S_IDLE && found) begin
        owner         <= win;
        spi_mosi_data <= wdata_x[win];
        // Counts of 32..63 would break the master's alignment loop.
        spi_nbits     <= wbits_x[win][5] ? 6'd31 : wbits_x[win];
      end
      if (state == S_BUSY && spi_ready) rdata <= spi_miso_data;
      if (state == S_DONE) last <= owner;
    end
  end

  assign busy        = (state != S_IDLE);
  assign spi_request = (state == S_GRANT);

  always_comb begin
    ack_x = '0;
    if (state == S_DONE) ack_x[owner] = 1'b1;
  end
  assign ack = ack_x[NPORTS-1:0];

  for (genvar k = 0; k < NPORTS; k++) begin : g_csn
    spi_arbiter_csn u_csn (
      .sel     (busy && (owner == PW'(k))),
      .spi_csn (spi_csn),
      .csn     (dev_csn[k])
    );
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural spi_master with MISO looped to MOSI,
// round-robin reference model, table of single transfers and corner sequences.

module tb_spi_arbiter;
  localparam int NP = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req;
  logic [32*NP-1:0] wdata;
  logic [6*NP-1:0]  wbits;
  logic [NP-1:0]    ack;
  logic [31:0]      rdata;
  logic             busy;
  logic [PW-1:0]    owner;
  logic             spi_request;
  logic [31:0]      spi_mosi_data;
  logic [5:0]       spi_nbits;
  logic [31:0]      spi_miso_data;
  logic             spi_ready;
  logic             spi_csn;
  logic [NP-1:0]    dev_csn;

  always #5 clk = ~clk;

  spi_arbiter #(.NPORTS(NP), .PW(PW)) dut (
    .clk_in(clk), .rst(rst), .req(req), .wdata(wdata), .wbits(wbits),
    .ack(ack), .rdata(rdata), .busy(busy), .owner(owner),
    .spi_request(spi_request), .spi_mosi_data(spi_mosi_data), .spi_nbits(spi_nbits),
    .spi_miso_data(spi_miso_data), .spi_ready(spi_ready), .spi_csn(spi_csn),
    .dev_csn(dev_csn)
  );

  function automatic logic [31:0] lowmask(logic [31:0] d, int nb);
    if (nb >= 31) return d;
    return d & ((32'd1 << (nb + 1)) - 32'd1);
  endfunction

  function automatic int clampf(int wb);
    return (wb >= 32) ? 31 : wb;
  endfunction

  function automatic int rr(logic [NP-1:0] r, int last);
    for (int i = 1; i <= NP; i++) begin
      int p;
      p = (last + i) % NP;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  // Behavioural master: accepts a request, clears ready a cycle later,
  // toggles one SCK per two clocks for nbits+1 bits, returns the looped word.
  logic        m_active;
  int          m_phase;
  logic [31:0] m_lat;
  logic [5:0]  m_nb;
  int          sck_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_phase <= 0; m_lat <= '0; m_nb <= '0; sck_cnt <= 0;
      spi_ready <= 1'b1; spi_csn <= 1'b1; spi_miso_data <= '0;
    end else if (!m_active) begin
      if (spi_request) begin
        m_active <= 1'b1; m_phase <= 0; m_lat <= spi_mosi_data; m_nb <= spi_nbits; sck_cnt <= 0;
      end
    end else begin
      spi_ready <= 1'b0;
      spi_csn   <= 1'b0;
      m_phase   <= m_phase + 1;
      if ((m_phase % 2) == 1) sck_cnt <= sck_cnt + 1;
      if (m_phase == 2 * (int'(m_nb) + 1)) begin
        m_active <= 1'b0; spi_ready <= 1'b1; spi_csn <= 1'b1;
        spi_miso_data <= lowmask(m_lat, int'(m_nb));
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int m_last = NP - 1;
  int exp_w = 0;
  int exp_nb = 0;
  logic [31:0] exp_rd;
  int grant_cyc = 0;
  bit outstanding = 0;
  bit busy_q = 0;
  int proto_bad = 0;
  int csn_bad = 0;
  int n_acks = 0;
  bit rereq = 0;
  bit rnd = 0;
  logic [NP-1:0] prev_drop = '0;
  int ack_order[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name, logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h", name, act);
  endtask

  task automatic step();
    logic [NP-1:0] drop;
    logic [NP-1:0] exp_csn;
    @(negedge clk);
    cyc++;
    drop = '0;
    if (busy && !busy_q) begin
      exp_w = rr(req, m_last);
      if (exp_w < 0) fail_now("grant_without_req", 32'(owner));
      else begin
        exp_nb = clampf(int'(wbits[6*exp_w +: 6]));
        exp_rd = lowmask(wdata[32*exp_w +: 32], exp_nb);
        check("grant_owner", 32'(owner), 32'(exp_w));
        check("grant_request", 32'(spi_request), 32'd1);
        check("grant_nbits", 32'(spi_nbits), 32'(exp_nb));
        check("grant_mosi", spi_mosi_data, wdata[32*exp_w +: 32]);
        grant_cyc = cyc;
        outstanding = 1;
      end
    end else if (spi_request) proto_bad++;
    exp_csn = '1;
    if (!spi_csn && outstanding) exp_csn[exp_w] = 1'b0;
    if (dev_csn !== exp_csn) csn_bad++;
    if (ack != '0) begin
      if (!outstanding) fail_now("ack_spurious", 32'(ack));
      else begin
        check("ack_port", 32'(ack), 32'(1) << exp_w);
        check("rdata", rdata, exp_rd);
        check("ack_latency", 32'(cyc - grant_cyc), 32'(2 * (exp_nb + 1) + 3));
        check("request_pulse", 32'(proto_bad), 32'd0);
        check("dev_csn_route", 32'(csn_bad), 32'd0);
        ack_order.push_back(exp_w);
        m_last = exp_w;
        outstanding = 0;
        req[exp_w] = 1'b0;
        drop[exp_w] = 1'b1;
        n_acks++;
      end
    end
    busy_q = busy;
    if (rereq) req = req | prev_drop;
    if (rnd) begin
      for (int p = 0; p < NP; p++) begin
        if (!req[p] && !drop[p] && $urandom_range(0, 5) == 0) begin
          req[p] = 1'b1;
          wdata[32*p +: 32] = $urandom;
          wbits[6*p +: 6] = 6'($urandom_range(0, 63));
        end
      end
    end
    prev_drop = drop;
  endtask

  task automatic run_acks(int n, int budget);
    int start;
    int c;
    start = n_acks;
    c = 0;
    while (n_acks - start < n && c < budget) begin
      step();
      c++;
    end
    if (n_acks - start < n) fail_now("ack_timeout", 32'(n_acks - start));
  endtask

  task automatic drain(int budget);
    int c;
    c = 0;
    rnd = 0;
    rereq = 0;
    while ((req != '0 || busy || outstanding) && c < budget) begin
      step();
      c++;
    end
    if (req != '0 || busy) fail_now("drain_timeout", 32'(req));
  endtask

  task automatic set_port(int p, logic [31:0] d, logic [5:0] b);
    wdata[32*p +: 32] = d;
    wbits[6*p +: 6] = b;
    req[p] = 1'b1;
  endtask

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [5:0]  bits;
    logic [5:0]  exp_nbits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[5];
  int rr_exp[5];

  initial begin
    tbl[0] = '{0, 32'h0000_00A5, 6'd7,  6'd7,  32'h0000_00A5};
    tbl[1] = '{1, 32'hDEAD_BEEF, 6'd40, 6'd31, 32'hDEAD_BEEF};
    tbl[2] = '{2, 32'h1234_5678, 6'd15, 6'd15, 32'h0000_5678};
    tbl[3] = '{2, 32'h8000_0001, 6'd63, 6'd31, 32'h8000_0001};
    tbl[4] = '{3, 32'hFFFF_FFFF, 6'd0,  6'd0,  32'h0000_0001};
    rr_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; wdata = '0; wbits = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_nbits", 32'(spi_nbits), 32'd0);
    check("rst_dev_csn", 32'(dev_csn), 32'hF);

    // Single transfers; entries 2 and 3 on port 2 run back to back.
    for (int i = 0; i < 5; i++) begin
      set_port(tbl[i].port, tbl[i].data, tbl[i].bits);
      run_acks(1, 300);
      check("tbl_owner", 32'(ack_order[$]), 32'(tbl[i].port));
      check("tbl_nbits", 32'(spi_nbits), 32'(tbl[i].exp_nbits));
      check("tbl_rdata", rdata, tbl[i].exp_rdata);
      check("tbl_sck", 32'(sck_cnt), 32'(tbl[i].exp_nbits) + 32'd1);
      step();
      check("tbl_ack_pulse", 32'(ack), 32'd0);
      check("tbl_busy_clear", 32'(busy), 32'd0);
    end

    // Round robin with every port re-requesting after its ack.
    begin
      int base;
      base = ack_order.size();
      for (int p = 0; p < NP; p++) set_port(p, $urandom, 6'($urandom_range(0, 20)));
      rereq = 1;
      run_acks(5, 1500);
      rereq = 0;
      for (int i = 0; i < 5; i++)
        if (base + i < ack_order.size()) check("rr_order", 32'(ack_order[base + i]), 32'(rr_exp[i]));
      drain(2000);
    end

    // Requester 0 abandons during BUSY; transfer still completes, port 1 next.
    begin
      int base;
      int c;
      base = ack_order.size();
      set_port(0, 32'hCAFE_0001, 6'd11);
      set_port(1, 32'hBEEF_0002, 6'd5);
      c = 0;
      while (!outstanding && c < 20) begin step(); c++; end
      step(); step();
      req[0] = 1'b0;
      run_acks(2, 600);
      if (ack_order.size() >= base + 2) begin
        check("abandon_first", 32'(ack_order[base]), 32'd0);
        check("abandon_next", 32'(ack_order[base + 1]), 32'd1);
      end
      drain(500);
    end

    // Randomized traffic against the round-robin model.
    rnd = 1;
    run_acks(30, 30 * 250);
    drain(3000);

    // Reset while the master is mid-transfer.
    begin
      int c;
      set_port(2, 32'h5555_AAAA, 6'd31);
      c = 0;
      while (!outstanding && c < 20) begin step(); c++; end
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ack", 32'(ack), 32'd0);
      check("mid_rst_owner", 32'(owner), 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      check("mid_rst_request", 32'(spi_request), 32'd0);
      check("mid_rst_mosi", spi_mosi_data, 32'd0);
      check("mid_rst_nbits", 32'(spi_nbits), 32'd0);
      check("mid_rst_dev_csn", 32'(dev_csn), 32'hF);
      @(negedge clk);
      rst = 1'b0;
      m_last = NP - 1; outstanding = 0; busy_q = 0; req = '0; prev_drop = '0;
      set_port(1, 32'h0F0F_1234, 6'd23);
      run_acks(1, 300);
      check("post_rst_owner", 32'(ack_order[$]), 32'd1);
      check("post_rst_rdata", rdata, 32'h000F_1234);
      drain(200);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
